// File: rtl/rf_wport_sched.sv
// Write-port arbiter for the 32x32 register file: writeback has priority, the
// long-latency unit gets a 1-entry holding buffer, a starvation guard and a busy scoreboard.
module rf_wport_sched #(
    parameter int MAX_OUT    = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_wr_i,
    input  logic [31:0] wb_wd_i,
    output logic        wb_stall_o,
    input  logic        ll_issue_i,
    input  logic [4:0]  ll_issue_rd_i,
    output logic        ll_full_o,
    input  logic        ll_valid_i,
    input  logic [4:0]  ll_rd_i,
    input  logic [31:0] ll_wd_i,
    output logic        ll_ready_o,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    output logic        hazard_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_wr_o,
    output logic [31:0] rf_wd_o
);

    localparam int         DATA_W   = 32;
    localparam logic [3:0] OCNT_MAX = 4'(MAX_OUT);
    localparam logic [3:0] WCNT_MAX = 4'(STARVE_MAX);

    typedef enum logic [2:0] {
        GRANT_NONE,
        GRANT_STARVE,
        GRANT_WB,
        GRANT_DRAIN,
        GRANT_DIRECT
    } grant_t;

    // Control state
    logic [31:0]       busy;
    logic              buf_v;
    logic [3:0]        wcnt;
    logic [3:0]        ocnt;

    // Buffered LL result (data only, qualified by buf_v)
    logic [4:0]        buf_rd;
    logic [DATA_W-1:0] buf_wd;

    grant_t            grant;
    logic              granted;
    logic              commit;
    logic [4:0]        wr_rd;
    logic [DATA_W-1:0] wr_wd;
    logic              accept;
    logic              buf_load;
    logic              issue_ok;
    logic [31:0]       busy_next;

    always_comb begin
        grant = GRANT_NONE;
        if (buf_v && (wcnt == WCNT_MAX)) begin
            grant = GRANT_STARVE;
        end else if (wb_we_i) begin
            grant = GRANT_WB;
        end else if (buf_v) begin
            grant = GRANT_DRAIN;
        end else if (ll_valid_i) begin
            grant = GRANT_DIRECT;
        end
    end

    always_comb begin
        wr_rd   = 5'd0;
        wr_wd   = '0;
        granted = 1'b0;
        commit  = 1'b0;
        case (grant)
            GRANT_STARVE, GRANT_DRAIN: begin
                wr_rd   = buf_rd;
                wr_wd   = buf_wd;
                granted = 1'b1;
                commit  = 1'b1;
            end
            GRANT_WB: begin
                wr_rd   = wb_wr_i;
                wr_wd   = wb_wd_i;
                granted = 1'b1;
            end
            GRANT_DIRECT: begin
                wr_rd   = ll_rd_i;
                wr_wd   = ll_wd_i;
                granted = 1'b1;
                commit  = 1'b1;
            end
            default: ;
        endcase
    end

    // r0 writes still consume the grant; only the RF enable is suppressed
    assign rf_we_o    = granted && (wr_rd != 5'd0);
    assign rf_wr_o    = wr_rd;
    assign rf_wd_o    = wr_wd;
    assign wb_stall_o = (grant == GRANT_STARVE) && wb_we_i;

    assign ll_ready_o = !buf_v;
    assign accept     = ll_valid_i && !buf_v;
    assign buf_load   = accept && (grant != GRANT_DIRECT);

    assign ll_full_o  = (ocnt == OCNT_MAX);
    assign issue_ok   = ll_issue_i && !ll_full_o;
    assign hazard_o   = busy[rs1_i] | busy[rs2_i] | busy[rd_i];

    // The set is applied after the clear so a same-cycle reissue keeps the bit
    always_comb begin
        busy_next = busy;
        if (commit) begin
            busy_next[wr_rd] = 1'b0;
        end
        if (issue_ok) begin
            busy_next[ll_issue_rd_i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy  <= '0;
            buf_v <= 1'b0;
            wcnt  <= 4'd0;
            ocnt  <= 4'd0;
        end else begin
            busy <= busy_next;

            if (buf_load) begin
                buf_v <= 1'b1;
                wcnt  <= 4'd0;
            end else if ((grant == GRANT_STARVE) || (grant == GRANT_DRAIN)) begin
                buf_v <= 1'b0;
                wcnt  <= 4'd0;
            end else if ((grant == GRANT_WB) && buf_v && (wcnt != 4'hF)) begin
                wcnt <= wcnt + 4'd1;
            end

            case ({issue_ok, commit})
                2'b10:   ocnt <= ocnt + 4'd1;
                2'b01:   if (ocnt != 4'd0) ocnt <= ocnt - 4'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (buf_load) begin
            buf_rd <= ll_rd_i;
            buf_wd <= ll_wd_i;
        end
    end

endmodule

// File: tb/tb_rf_wport_sched.sv
// Scenario bench for rf_wport_sched: expected RF writes are queued when driven
// and popped whenever the DUT asserts rf_we_o.
module tb_rf_wport_sched;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_wr;
    logic [31:0] wb_wd;
    logic        wb_stall;
    logic        ll_issue;
    logic [4:0]  ll_issue_rd;
    logic        ll_full;
    logic        ll_valid;
    logic [4:0]  ll_rd;
    logic [31:0] ll_wd;
    logic        ll_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        hazard;
    logic        rf_we;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;

    int checks = 0;
    int fails  = 0;
    logic [36:0] exp_q[$];

    rf_wport_sched #(.MAX_OUT(4), .STARVE_MAX(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .wb_we_i(wb_we), .wb_wr_i(wb_wr), .wb_wd_i(wb_wd), .wb_stall_o(wb_stall),
        .ll_issue_i(ll_issue), .ll_issue_rd_i(ll_issue_rd), .ll_full_o(ll_full),
        .ll_valid_i(ll_valid), .ll_rd_i(ll_rd), .ll_wd_i(ll_wd), .ll_ready_o(ll_ready),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .hazard_o(hazard),
        .rf_we_o(rf_we), .rf_wr_o(rf_wr), .rf_wd_o(rf_wd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        wb_we = 1'b0; wb_wr = 5'd0; wb_wd = 32'd0;
        ll_issue = 1'b0; ll_issue_rd = 5'd0;
        ll_valid = 1'b0; ll_rd = 5'd0; ll_wd = 32'd0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    endtask

    // Mid-cycle sample; any RF write must match the head of the queue
    task automatic sample();
        logic [36:0] e;
        @(negedge clk);
        if (rf_we !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rf_write: got write r%0d=%h, required no write", rf_wr, rf_wd);
            end else begin
                e = exp_q.pop_front();
                if ({rf_wr, rf_wd} !== e)
                    begin fails++; $display("FAIL rf_write: got r%0d=%h, required r%0d=%h", rf_wr, rf_wd, e[36:32], e[31:0]); end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        advance();
        wb_we = 1'b1; wb_wr = 5'd2; wb_wd = 32'h55;
        rs1 = 5'd9; rs2 = 5'd3; rd = 5'd31;
        exp_q.push_back({5'd2, 32'h55});
        sample();
        checks++; if (ll_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b, required 1", ll_ready); end
        checks++; if (ll_full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b, required 0", ll_full); end
        checks++; if (hazard !== 1'b0) begin fails++; $display("FAIL reset_hazard: got %b, required 0", hazard); end
        checks++; if (wb_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b, required 0", wb_stall); end
        advance();
        wb_wr = 5'd0;
        sample();
        checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL reset_r0_we: got %b, required 0", rf_we); end
        advance();
        rst = 1'b0;
        idle();
        advance();
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL reset_pending: got %0d queued, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_wb_only();
        wb_we = 1'b1; wb_wr = 5'd5; wb_wd = 32'h1234;
        exp_q.push_back({5'd5, 32'h1234});
        sample();
        checks++; if (rf_we !== 1'b1) begin fails++; $display("FAIL wb_we: got %b, required 1", rf_we); end
        checks++; if (rf_wr !== 5'd5) begin fails++; $display("FAIL wb_wr: got %0d, required 5", rf_wr); end
        checks++; if (rf_wd !== 32'h1234) begin fails++; $display("FAIL wb_wd: got %h, required 1234", rf_wd); end
        checks++; if (wb_stall !== 1'b0) begin fails++; $display("FAIL wb_stall: got %b, required 0", wb_stall); end
        advance();
        wb_wr = 5'd0; wb_wd = 32'hBEEF;
        sample();
        checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL wb_r0_we: got %b, required 0", rf_we); end
        advance();
        idle();
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL wb_pending: got %0d queued, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_scoreboard();
        ll_issue = 1'b1; ll_issue_rd = 5'd7; rs1 = 5'd7;
        sample();
        checks++; if (hazard !== 1'b0) begin fails++; $display("FAIL sb_same_cycle: got %b, required 0", hazard); end
        advance();
        ll_issue = 1'b0;
        sample();
        checks++; if (hazard !== 1'b1) begin fails++; $display("FAIL sb_rs1_busy: got %b, required 1", hazard); end
        advance();
        rs1 = 5'd0; rd = 5'd7;
        ll_valid = 1'b1; ll_rd = 5'd7; ll_wd = 32'hAA;
        exp_q.push_back({5'd7, 32'hAA});
        sample();
        checks++; if (ll_ready !== 1'b1) begin fails++; $display("FAIL sb_ready: got %b, required 1", ll_ready); end
        checks++; if (hazard !== 1'b1) begin fails++; $display("FAIL sb_rd_busy: got %b, required 1", hazard); end
        advance();
        ll_valid = 1'b0; rs1 = 5'd7;
        sample();
        checks++; if (hazard !== 1'b0) begin fails++; $display("FAIL sb_cleared: got %b, required 0", hazard); end
        advance();
        idle();
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL sb_pending: got %0d queued, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_collision();
        ll_issue = 1'b1; ll_issue_rd = 5'd3;
        sample();
        advance();
        ll_issue = 1'b0;
        wb_we = 1'b1; wb_wr = 5'd4; wb_wd = 32'h44;
        ll_valid = 1'b1; ll_rd = 5'd3; ll_wd = 32'h33;
        exp_q.push_back({5'd4, 32'h44});
        sample();
        checks++; if (ll_ready !== 1'b1) begin fails++; $display("FAIL col_accept: got %b, required 1", ll_ready); end
        advance();
        ll_valid = 1'b0;
        wb_wr = 5'd6; wb_wd = 32'h66; rs1 = 5'd3;
        exp_q.push_back({5'd6, 32'h66});
        sample();
        checks++; if (ll_ready !== 1'b0) begin fails++; $display("FAIL col_ready_low: got %b, required 0", ll_ready); end
        checks++; if (hazard !== 1'b1) begin fails++; $display("FAIL col_busy: got %b, required 1", hazard); end
        advance();
        wb_we = 1'b0;
        exp_q.push_back({5'd3, 32'h33});
        sample();
        checks++; if (rf_wr !== 5'd3) begin fails++; $display("FAIL col_drain_wr: got %0d, required 3", rf_wr); end
        advance();
        sample();
        checks++; if (ll_ready !== 1'b1) begin fails++; $display("FAIL col_ready_back: got %b, required 1", ll_ready); end
        checks++; if (hazard !== 1'b0) begin fails++; $display("FAIL col_cleared: got %b, required 0", hazard); end
        advance();
        idle();
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL col_pending: got %0d queued, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_starvation();
        ll_issue = 1'b1; ll_issue_rd = 5'd10;
        sample();
        advance();
        ll_issue = 1'b0;
        wb_we = 1'b1; wb_wr = 5'd11; wb_wd = 32'h100;
        ll_valid = 1'b1; ll_rd = 5'd10; ll_wd = 32'hA0;
        exp_q.push_back({5'd11, 32'h100});
        sample();
        advance();
        ll_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            wb_wr = 5'(11 + i); wb_wd = 32'h100 + 32'(i);
            exp_q.push_back({5'(11 + i), 32'h100 + 32'(i)});
            sample();
            checks++; if (wb_stall !== 1'b0) begin fails++; $display("FAIL starve_wb%0d_stall: got %b, required 0", i, wb_stall); end
            checks++; if (ll_ready !== 1'b0) begin fails++; $display("FAIL starve_wb%0d_ready: got %b, required 0", i, ll_ready); end
            advance();
        end
        wb_wr = 5'd15; wb_wd = 32'h104;
        exp_q.push_back({5'd10, 32'hA0});
        sample();
        checks++; if (wb_stall !== 1'b1) begin fails++; $display("FAIL starve_stall: got %b, required 1", wb_stall); end
        advance();
        exp_q.push_back({5'd15, 32'h104});
        sample();
        checks++; if (wb_stall !== 1'b0) begin fails++; $display("FAIL starve_retry_stall: got %b, required 0", wb_stall); end
        checks++; if (ll_ready !== 1'b1) begin fails++; $display("FAIL starve_ready: got %b, required 1", ll_ready); end
        advance();
        idle();
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL starve_pending: got %0d queued, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_full_r0();
        logic [4:0] iss[4];
        logic [4:0] cmt[4];
        iss[0] = 5'd1; iss[1] = 5'd0; iss[2] = 5'd2; iss[3] = 5'd8;
        cmt[0] = 5'd1; cmt[1] = 5'd2; cmt[2] = 5'd8; cmt[3] = 5'd21;
        for (int i = 0; i < 4; i++) begin
            ll_issue = 1'b1; ll_issue_rd = iss[i];
            sample();
            checks++; if (ll_full !== 1'b0) begin fails++; $display("FAIL full_early%0d: got %b, required 0", i, ll_full); end
            advance();
        end
        ll_issue_rd = 5'd20;
        sample();
        checks++; if (ll_full !== 1'b1) begin fails++; $display("FAIL full_set: got %b, required 1", ll_full); end
        advance();
        ll_issue = 1'b0; rs1 = 5'd20;
        ll_valid = 1'b1; ll_rd = 5'd0; ll_wd = 32'hDEAD;
        sample();
        checks++; if (hazard !== 1'b0) begin fails++; $display("FAIL full_ignored_busy: got %b, required 0", hazard); end
        checks++; if (ll_full !== 1'b1) begin fails++; $display("FAIL full_ignored_cnt: got %b, required 1", ll_full); end
        checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL full_r0_we: got %b, required 0", rf_we); end
        advance();
        ll_valid = 1'b0; rs1 = 5'd0;
        ll_issue = 1'b1; ll_issue_rd = 5'd21;
        sample();
        checks++; if (ll_full !== 1'b0) begin fails++; $display("FAIL full_after_r0: got %b, required 0", ll_full); end
        advance();
        ll_issue = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ll_valid = 1'b1; ll_rd = cmt[i]; ll_wd = 32'h1000 + 32'(cmt[i]);
            exp_q.push_back({cmt[i], 32'h1000 + 32'(cmt[i])});
            sample();
            if (i == 0) begin
                checks++; if (ll_full !== 1'b1) begin fails++; $display("FAIL full_refill: got %b, required 1", ll_full); end
            end
            advance();
        end
        idle();
        rs1 = 5'd8; rs2 = 5'd21; rd = 5'd1;
        sample();
        checks++; if (ll_full !== 1'b0) begin fails++; $display("FAIL full_drained: got %b, required 0", ll_full); end
        checks++; if (hazard !== 1'b0) begin fails++; $display("FAIL full_hazard: got %b, required 0", hazard); end
        advance();
        idle();
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL full_pending: got %0d queued, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        ll_issue = 1'b1; ll_issue_rd = 5'd22;
        sample();
        advance();
        ll_valid = 1'b1; ll_rd = 5'd22; ll_wd = 32'h2222;
        exp_q.push_back({5'd22, 32'h2222});
        sample();
        advance();
        ll_issue = 1'b0; rs1 = 5'd22;
        ll_wd = 32'h2223;
        exp_q.push_back({5'd22, 32'h2223});
        sample();
        checks++; if (hazard !== 1'b1) begin fails++; $display("FAIL b2b_set_wins: got %b, required 1", hazard); end
        advance();
        ll_valid = 1'b0;
        sample();
        checks++; if (hazard !== 1'b0) begin fails++; $display("FAIL b2b_cleared: got %b, required 0", hazard); end
        checks++; if (ll_full !== 1'b0) begin fails++; $display("FAIL b2b_full: got %b, required 0", ll_full); end
        advance();
        idle();
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_pending: got %0d queued, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        ll_issue = 1'b1; ll_issue_rd = 5'd9;
        sample();
        advance();
        ll_issue_rd = 5'd5;
        sample();
        advance();
        ll_issue = 1'b0;
        wb_we = 1'b1; wb_wr = 5'd4; wb_wd = 32'h4;
        ll_valid = 1'b1; ll_rd = 5'd5; ll_wd = 32'h55;
        exp_q.push_back({5'd4, 32'h4});
        sample();
        advance();
        rst = 1'b1;
        ll_valid = 1'b0;
        wb_wr = 5'd6; wb_wd = 32'h77;
        exp_q.push_back({5'd6, 32'h77});
        sample();
        checks++; if (ll_ready !== 1'b0) begin fails++; $display("FAIL rmid_buffered: got %b, required 0", ll_ready); end
        advance();
        rst = 1'b0;
        idle();
        rs1 = 5'd9;
        sample();
        checks++; if (ll_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready: got %b, required 1", ll_ready); end
        checks++; if (hazard !== 1'b0) begin fails++; $display("FAIL rmid_hazard: got %b, required 0", hazard); end
        checks++; if (ll_full !== 1'b0) begin fails++; $display("FAIL rmid_full: got %b, required 0", ll_full); end
        checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL rmid_no_drain: got %b, required 0", rf_we); end
        advance();
        idle();
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL rmid_pending: got %0d queued, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_wb_only();
        test_scoreboard();
        test_collision();
        test_starvation();
        test_full_r0();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/rf_wport_sched.md
# rf_wport_sched

Write-port scheduler and scoreboard for the 32x32 register file (RF, `r0` hardwired to zero, one write port).
- Shares the single RF write port between two requesters:
  - pipeline writeback (WB), which has priority;
  - the long-latency unit (LL: multiply/divide, slow loads), which uses a valid/ready handshake and a 1-entry holding buffer.
- Tracks registers with outstanding LL writes and flags RAW/WAW hazards to decode.
- Guarantees LL forward progress by stalling WB after a bounded wait.

## Interface
Parameters:
- `MAX_OUT`, 4: maximum outstanding LL operations (issued, not yet committed); 1..15.
- `STARVE_MAX`, 3: cycles a buffered LL result may wait before WB is stalled; 1..15.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `wb_we_i`  in  1  WB write request.
- `wb_wr_i`  in  5  WB destination register.
- `wb_wd_i`  in  32  WB write data.
- `wb_stall_o`  out  1  WB write not taken this cycle; pipeline holds WB and retries.
- `ll_issue_i`  in  1  decode issues an LL operation this cycle.
- `ll_issue_rd_i`  in  5  destination of the issued LL operation.
- `ll_full_o`  out  1  outstanding count == `MAX_OUT`.
- `ll_valid_i`  in  1  LL result valid.
- `ll_rd_i`  in  5  LL result destination.
- `ll_wd_i`  in  32  LL result data.
- `ll_ready_o`  out  1  LL result accepted when high together with `ll_valid_i`.
- `rs1_i`, `rs2_i`, `rd_i`  in  5 each  decode operand and destination indices.
- `hazard_o`  out  1  `busy[rs1_i] | busy[rs2_i] | busy[rd_i]`; `busy[0]` is always 0.
- `rf_we_o`  out  1  RF write enable (RF `op`).
- `rf_wr_o`  out  5  RF write address.
- `rf_wd_o`  out  32  RF write data.

## Operation
State:
- `busy[31:1]` scoreboard bits.
- Holding buffer `buf_v`, `buf_rd`, `buf_wd`.
- Wait counter `wcnt`, 4 bits.
- Outstanding counter `ocnt`, 4 bits.

Port grant, evaluated each cycle in priority order (combinational):
- **STARVE**: `buf_v && wcnt == STARVE_MAX`.
  - Buffer gets the port.
  - `wb_stall_o = wb_we_i`.
  - The WB request is not written.
- **WB**: `wb_we_i`. WB gets the port. A buffered entry waits; `wcnt` increments.
- **DRAIN**: `buf_v`, no WB. Buffer gets the port; `buf_v` clears; `wcnt` → 0.
- **DIRECT**: `ll_valid_i && ll_ready_o`, no WB, no buffer. The LL result is written straight through.
- Otherwise `rf_we_o = 0`.

Handshake and buffering:
- `ll_ready_o = !buf_v`.
- An accepted LL result that does not get the port in that cycle loads the buffer; `wcnt` → 0.
- One LL result is committed per cycle at most.

Register-0 rule:
- Any granted write with destination 0 drives `rf_we_o = 0`, but still counts as granted.
- Applies to WB, buffer and direct writes.

Scoreboard:
- Set: on `ll_issue_i && !ll_full_o` with `ll_issue_rd_i != 0`, `busy[ll_issue_rd_i]` sets.
- Clear: an LL commit (DRAIN, STARVE or DIRECT) clears `busy[dest]`.
- Same register set and cleared in one cycle: the set wins.
- `ll_issue_i` while `ll_full_o` is ignored: no set, no count.
- Suppressing issues on `hazard_o` is the decoder's job.

Outstanding count:
- `ocnt` +1 on an accepted issue (including rd = 0).
- `ocnt` −1 on an LL commit.
- Both in one cycle: unchanged.
- `ll_full_o = (ocnt == MAX_OUT)`.

## Timing
- `rf_*`, `wb_stall_o`, `ll_ready_o`, `hazard_o` and `ll_full_o` are combinational from state and current inputs.
- The RF captures the write on the same edge; zero added latency on the WB path.
- An LL result with a free port is written in its acceptance cycle.
- A buffered result is written no later than `STARVE_MAX` cycles after capture.
- `busy` updates are visible on `hazard_o` the cycle after the edge.
  - A commit in cycle N clears `hazard_o` in N+1.
  - The decoder reads the RF after the write edge, so no bypass is needed.
- Reset state:
  - `busy` = 0, `buf_v` = 0, `wcnt` = 0, `ocnt` = 0.
  - Hence `ll_ready_o = 1`, `ll_full_o = 0`, `hazard_o = 0`, `wb_stall_o = 0`.
  - `rf_we_o` follows `wb_we_i`, with the register-0 rule applied.
- Reset mid-operation discards the buffered result and all pending busy bits. The LL unit is reset by the same `rst_i`.

## Test plan
- WB only:
  - Stimulus: `wb_we_i = 1`, `wb_wr_i = 5`, `wb_wd_i = 0x1234`.
  - Required: `rf_we_o = 1`, `rf_wr_o = 5`, `rf_wd_o = 0x1234` in the same cycle; `wb_stall_o = 0`.
- Scoreboard:
  - Stimulus: issue LL to r7; next cycle `rs1_i = 7`.
  - Required: `hazard_o = 1`. After the LL result for r7 (`0xAA`) commits directly, `hazard_o = 0` the next cycle and the RF receives r7 = `0xAA`.
- Collision:
  - Stimulus: `ll_valid_i` (r3, `0x33`) in the same cycle as WB (r4).
  - Required: WB written; result buffered; `ll_ready_o = 0` next cycle; r3 written in the first cycle without WB.
- Starvation:
  - Stimulus: buffered result, continuous `wb_we_i`, `STARVE_MAX = 3`.
  - Required: three WB writes, then the buffer is written with `wb_stall_o = 1`; the retried WB is written the following cycle.
- Full and register 0:
  - Stimulus: four issues, one of them to r0, with `MAX_OUT = 4`.
  - Required: `ll_full_o = 1`; a fifth issue is ignored; the r0 commit has `rf_we_o = 0` and `ocnt` falls to 3.
- Reset mid-operation:
  - Stimulus: `rst_i` with `buf_v = 1` and r9 busy.
  - Required: next cycle `ll_ready_o = 1`, `hazard_o = 0` for `rs1_i = 9`, `ll_full_o = 0`.
